// File: rtl/crtc_regs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crtc_pkg - register indices, field widths and PET 40-col defaults     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package crtc_pkg;

    typedef logic [4:0] crtc_addr_t;

    localparam crtc_addr_t CRTC_R_HTOTAL     = 5'd0;
    localparam crtc_addr_t CRTC_R_HDISP      = 5'd1;
    localparam crtc_addr_t CRTC_R_HSYNCPOS   = 5'd2;
    localparam crtc_addr_t CRTC_R_SYNCWIDTH  = 5'd3;
    localparam crtc_addr_t CRTC_R_VTOTAL     = 5'd4;
    localparam crtc_addr_t CRTC_R_VADJUST    = 5'd5;
    localparam crtc_addr_t CRTC_R_VDISP      = 5'd6;
    localparam crtc_addr_t CRTC_R_VSYNCPOS   = 5'd7;
    localparam crtc_addr_t CRTC_R_MODE       = 5'd8;
    localparam crtc_addr_t CRTC_R_CHARHEIGHT = 5'd9;
    localparam crtc_addr_t CRTC_R_START_HI   = 5'd12;
    localparam crtc_addr_t CRTC_R_START_LO   = 5'd13;
    localparam crtc_addr_t CRTC_R_CURSOR_HI  = 5'd14;
    localparam crtc_addr_t CRTC_R_CURSOR_LO  = 5'd15;

    localparam int CRTC_W_R4  = 7;
    localparam int CRTC_W_R5  = 5;
    localparam int CRTC_W_R6  = 7;
    localparam int CRTC_W_R7  = 7;
    localparam int CRTC_W_R9  = 5;
    localparam int CRTC_W_R12 = 6;
    localparam int CRTC_W_R14 = 6;

    localparam logic [7:0] CRTC_RST_R0 = 8'd49;
    localparam logic [7:0] CRTC_RST_R1 = 8'd40;
    localparam logic [7:0] CRTC_RST_R2 = 8'd41;
    localparam logic [7:0] CRTC_RST_R3 = 8'h1F;
    localparam logic [7:0] CRTC_RST_R4 = 8'd32;
    localparam logic [7:0] CRTC_RST_R5 = 8'd5;
    localparam logic [7:0] CRTC_RST_R6 = 8'd25;
    localparam logic [7:0] CRTC_RST_R7 = 8'd29;
    localparam logic [7:0] CRTC_RST_R9 = 8'd7;

    // Registers that go through the shadow/active pair.
    function automatic logic crtc_is_buffered(input crtc_addr_t a);
        return (a <= CRTC_R_VSYNCPOS) || (a == CRTC_R_CHARHEIGHT) ||
               (a == CRTC_R_START_HI) || (a == CRTC_R_START_LO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crtc_regs_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crtc_regs_if - CPU address/data register-pair access port             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface crtc_regs_if;
    logic       cpu_en;
    logic       cpu_rw;
    logic       cpu_rs;
    logic [7:0] cpu_data_in;
    logic [7:0] cpu_data_out;

    modport master (output cpu_en, cpu_rw, cpu_rs, cpu_data_in, input cpu_data_out);
    modport slave  (input cpu_en, cpu_rw, cpu_rs, cpu_data_in, output cpu_data_out);
endinterface
`default_nettype wire

// File: rtl/crtc_regs_shadow_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crtc_shadow_reg - shadow register with frame-boundary active copy     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module crtc_shadow_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             xfer_i,
    output logic      [WIDTH-1:0] active_o
);

    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] active_q;

    // Transfer samples the pre-write shadow, so a same-cycle write waits a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= RST_VAL;
            active_q <= RST_VAL;
        end else begin
            if (load_i) shadow_q <= data_i;
            if (xfer_i) active_q <= shadow_q;
        end
    end

    assign active_o = active_q;

endmodule
`default_nettype wire

// File: rtl/crtc_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crtc_regs - 6545-style CRTC register file with double-buffered timing |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module crtc_regs
    import crtc_pkg::*;
#(
    parameter bit         FRAME_SYNC = 1'b1,
    parameter logic [7:0] RST_R0     = CRTC_RST_R0,
    parameter logic [7:0] RST_R1     = CRTC_RST_R1,
    parameter logic [7:0] RST_R2     = CRTC_RST_R2,
    parameter logic [7:0] RST_R3     = CRTC_RST_R3,
    parameter logic [7:0] RST_R4     = CRTC_RST_R4,
    parameter logic [7:0] RST_R5     = CRTC_RST_R5,
    parameter logic [7:0] RST_R6     = CRTC_RST_R6,
    parameter logic [7:0] RST_R7     = CRTC_RST_R7,
    parameter logic [7:0] RST_R9     = CRTC_RST_R9
) (
    input  wire logic        pixel_clk,
    input  wire logic        reset,
    crtc_regs_if.slave       cpu,
    input  wire logic        frame_start,
    output logic [7:0]       h_char_total,
    output logic [7:0]       h_char_displayed,
    output logic [7:0]       h_sync_pos,
    output logic [3:0]       h_sync_width,
    output logic [3:0]       v_sync_width,
    output logic [6:0]       v_char_total,
    output logic [4:0]       v_adjust,
    output logic [6:0]       v_char_displayed,
    output logic [6:0]       v_sync_pos,
    output logic [4:0]       v_char_height,
    output logic [13:0]      start_addr,
    output logic [13:0]      cursor_addr,
    output logic             pending
);

    logic       w_wr_addr, w_wr_data, w_rd, w_buf_wr, w_xfer;
    logic [7:0] w_d;
    crtc_addr_t addr_q;
    logic       pending_q, pending_d;
    logic [7:0] rdata_q, rdata_d;
    logic [CRTC_W_R14-1:0] r14_q;
    logic [7:0]            r15_q;
    logic [7:0]            w_r3;
    logic [CRTC_W_R12-1:0] w_r12;
    logic [7:0]            w_r13;

    assign w_d       = cpu.cpu_data_in;
    assign w_wr_addr = cpu.cpu_en & ~cpu.cpu_rw & ~cpu.cpu_rs;
    assign w_wr_data = cpu.cpu_en & ~cpu.cpu_rw &  cpu.cpu_rs;
    assign w_rd      = cpu.cpu_en &  cpu.cpu_rw;
    assign w_buf_wr  = w_wr_data & crtc_is_buffered(addr_q);
    assign w_xfer    = FRAME_SYNC ? (frame_start & pending_q) : 1'b1;

    crtc_shadow_reg #(.WIDTH(8), .RST_VAL(RST_R0)) u_r0 (
        .clk(pixel_clk), .rst(reset), .load_i(w_wr_data && addr_q == CRTC_R_HTOTAL),
        .data_i(w_d), .xfer_i(w_xfer), .active_o(h_char_total));
    crtc_shadow_reg #(.WIDTH(8), .RST_VAL(RST_R1)) u_r1 (
        .clk(pixel_clk), .rst(reset), .load_i(w_wr_data && addr_q == CRTC_R_HDISP),
        .data_i(w_d), .xfer_i(w_xfer), .active_o(h_char_displayed));
    crtc_shadow_reg #(.WIDTH(8), .RST_VAL(RST_R2)) u_r2 (
        .clk(pixel_clk), .rst(reset), .load_i(w_wr_data && addr_q == CRTC_R_HSYNCPOS),
        .data_i(w_d), .xfer_i(w_xfer), .active_o(h_sync_pos));
    crtc_shadow_reg #(.WIDTH(8), .RST_VAL(RST_R3)) u_r3 (
        .clk(pixel_clk), .rst(reset), .load_i(w_wr_data && addr_q == CRTC_R_SYNCWIDTH),
        .data_i(w_d), .xfer_i(w_xfer), .active_o(w_r3));
    crtc_shadow_reg #(.WIDTH(CRTC_W_R4), .RST_VAL(RST_R4[CRTC_W_R4-1:0])) u_r4 (
        .clk(pixel_clk), .rst(reset), .load_i(w_wr_data && addr_q == CRTC_R_VTOTAL),
        .data_i(w_d[CRTC_W_R4-1:0]), .xfer_i(w_xfer), .active_o(v_char_total));
    crtc_shadow_reg #(.WIDTH(CRTC_W_R5), .RST_VAL(RST_R5[CRTC_W_R5-1:0])) u_r5 (
        .clk(pixel_clk), .rst(reset), .load_i(w_wr_data && addr_q == CRTC_R_VADJUST),
        .data_i(w_d[CRTC_W_R5-1:0]), .xfer_i(w_xfer), .active_o(v_adjust));
    crtc_shadow_reg #(.WIDTH(CRTC_W_R6), .RST_VAL(RST_R6[CRTC_W_R6-1:0])) u_r6 (
        .clk(pixel_clk), .rst(reset), .load_i(w_wr_data && addr_q == CRTC_R_VDISP),
        .data_i(w_d[CRTC_W_R6-1:0]), .xfer_i(w_xfer), .active_o(v_char_displayed));
    crtc_shadow_reg #(.WIDTH(CRTC_W_R7), .RST_VAL(RST_R7[CRTC_W_R7-1:0])) u_r7 (
        .clk(pixel_clk), .rst(reset), .load_i(w_wr_data && addr_q == CRTC_R_VSYNCPOS),
        .data_i(w_d[CRTC_W_R7-1:0]), .xfer_i(w_xfer), .active_o(v_sync_pos));
    crtc_shadow_reg #(.WIDTH(CRTC_W_R9), .RST_VAL(RST_R9[CRTC_W_R9-1:0])) u_r9 (
        .clk(pixel_clk), .rst(reset), .load_i(w_wr_data && addr_q == CRTC_R_CHARHEIGHT),
        .data_i(w_d[CRTC_W_R9-1:0]), .xfer_i(w_xfer), .active_o(v_char_height));
    crtc_shadow_reg #(.WIDTH(CRTC_W_R12), .RST_VAL('0)) u_r12 (
        .clk(pixel_clk), .rst(reset), .load_i(w_wr_data && addr_q == CRTC_R_START_HI),
        .data_i(w_d[CRTC_W_R12-1:0]), .xfer_i(w_xfer), .active_o(w_r12));
    crtc_shadow_reg #(.WIDTH(8), .RST_VAL('0)) u_r13 (
        .clk(pixel_clk), .rst(reset), .load_i(w_wr_data && addr_q == CRTC_R_START_LO),
        .data_i(w_d), .xfer_i(w_xfer), .active_o(w_r13));

    // Pending clears on transfer but a coincident buffered write re-arms it.
    always_comb begin
        pending_d = pending_q;
        if (w_xfer)   pending_d = 1'b0;
        if (w_buf_wr) pending_d = 1'b1;
        if (!FRAME_SYNC) pending_d = 1'b0;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (w_rd) begin
            if (!cpu.cpu_rs)                        rdata_d = {pending_q, 2'b00, addr_q};
            else if (addr_q == CRTC_R_CURSOR_HI)    rdata_d = {2'b00, r14_q};
            else if (addr_q == CRTC_R_CURSOR_LO)    rdata_d = r15_q;
            else                                    rdata_d = 8'h00;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            addr_q    <= '0;
            pending_q <= 1'b0;
            rdata_q   <= 8'h00;
            r14_q     <= '0;
            r15_q     <= '0;
        end else begin
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
            if (w_wr_addr) addr_q <= w_d[4:0];
            if (w_wr_data && addr_q == CRTC_R_CURSOR_HI) r14_q <= w_d[CRTC_W_R14-1:0];
            if (w_wr_data && addr_q == CRTC_R_CURSOR_LO) r15_q <= w_d;
        end
    end

    assign h_sync_width     = w_r3[3:0];
    assign v_sync_width     = w_r3[7:4];
    assign start_addr       = {w_r12, w_r13};
    assign cursor_addr      = {r14_q, r15_q};
    assign pending          = pending_q;
    assign cpu.cpu_data_out = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_crtc_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_crtc_regs - frame-synced and immediate instances vs. array model   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_crtc_regs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s;
    logic fs_s;

    crtc_regs_if bus0 ();
    crtc_regs_if bus1 ();

    logic [7:0]  hct [2];
    logic [7:0]  hcd [2];
    logic [7:0]  hsp [2];
    logic [3:0]  hsw [2];
    logic [3:0]  vsw [2];
    logic [6:0]  vct [2];
    logic [4:0]  vadj[2];
    logic [6:0]  vcd [2];
    logic [6:0]  vsp [2];
    logic [4:0]  vch [2];
    logic [13:0] sta [2];
    logic [13:0] cur [2];
    logic        pnd [2];

    crtc_regs #(.FRAME_SYNC(1'b1)) dut0 (
        .pixel_clk(clk), .reset(rst_s), .cpu(bus0), .frame_start(fs_s),
        .h_char_total(hct[0]), .h_char_displayed(hcd[0]), .h_sync_pos(hsp[0]),
        .h_sync_width(hsw[0]), .v_sync_width(vsw[0]), .v_char_total(vct[0]),
        .v_adjust(vadj[0]), .v_char_displayed(vcd[0]), .v_sync_pos(vsp[0]),
        .v_char_height(vch[0]), .start_addr(sta[0]), .cursor_addr(cur[0]),
        .pending(pnd[0]));

    crtc_regs #(.FRAME_SYNC(1'b0)) dut1 (
        .pixel_clk(clk), .reset(rst_s), .cpu(bus1), .frame_start(fs_s),
        .h_char_total(hct[1]), .h_char_displayed(hcd[1]), .h_sync_pos(hsp[1]),
        .h_sync_width(hsw[1]), .v_sync_width(vsw[1]), .v_char_total(vct[1]),
        .v_adjust(vadj[1]), .v_char_displayed(vcd[1]), .v_sync_pos(vsp[1]),
        .v_char_height(vch[1]), .start_addr(sta[1]), .cursor_addr(cur[1]),
        .pending(pnd[1]));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents as 16 plain bytes per instance.
    logic [7:0] m_act [2][16];
    logic [7:0] m_sh  [2][16];
    logic [4:0] m_addr[2];
    logic       m_pend[2];
    logic [7:0] m_rd  [2];

    function automatic logic [7:0] mask_of(input int a);
        case (a)
            4, 6, 7:  return 8'h7F;
            5, 9:     return 8'h1F;
            12, 14:   return 8'h3F;
            default:  return 8'hFF;
        endcase
    endfunction

    function automatic bit buffered(input int a);
        return (a <= 7) || a == 9 || a == 12 || a == 13;
    endfunction

    function automatic logic [7:0] rst_of(input int a);
        case (a)
            0: return 8'd49;  1: return 8'd40;  2: return 8'd41;
            3: return 8'h1F;  4: return 8'd32;  5: return 8'd5;
            6: return 8'd25;  7: return 8'd29;  9: return 8'd7;
            default: return 8'd0;
        endcase
    endfunction

    task automatic model_step(input int k, input bit fsync, input bit r, input bit en,
                              input bit rw, input bit rs, input logic [7:0] d, input bit f);
        logic [7:0] old_sh[16];
        bit         xfer;
        int         a;
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                m_sh[k][i]  = rst_of(i);
                m_act[k][i] = rst_of(i);
            end
            m_addr[k] = '0; m_pend[k] = 1'b0; m_rd[k] = 8'h00;
            return;
        end
        a = int'(m_addr[k]);
        if (en && rw)
            m_rd[k] = !rs ? {m_pend[k], 2'b00, m_addr[k]} :
                      (a == 14 || a == 15) ? m_act[k][a] : 8'h00;
        for (int i = 0; i < 16; i++) old_sh[i] = m_sh[k][i];
        xfer = fsync ? (f && m_pend[k]) : 1'b1;
        if (xfer) begin
            for (int i = 0; i < 16; i++)
                if (buffered(i)) m_act[k][i] = old_sh[i];
            m_pend[k] = 1'b0;
        end
        if (en && !rw) begin
            if (!rs) m_addr[k] = d[4:0];
            else if (buffered(a)) begin
                m_sh[k][a] = d & mask_of(a);
                if (fsync) m_pend[k] = 1'b1;
            end else if (a == 14 || a == 15)
                m_act[k][a] = d & mask_of(a);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int k);
        string p;
        p = $sformatf("i%0d.", k);
        chk({p, "hct"},  32'(hct[k]),  32'(m_act[k][0]));
        chk({p, "hcd"},  32'(hcd[k]),  32'(m_act[k][1]));
        chk({p, "hsp"},  32'(hsp[k]),  32'(m_act[k][2]));
        chk({p, "hsw"},  32'(hsw[k]),  32'(m_act[k][3] & 8'h0F));
        chk({p, "vsw"},  32'(vsw[k]),  32'(m_act[k][3] >> 4));
        chk({p, "vct"},  32'(vct[k]),  32'(m_act[k][4]));
        chk({p, "vadj"}, 32'(vadj[k]), 32'(m_act[k][5]));
        chk({p, "vcd"},  32'(vcd[k]),  32'(m_act[k][6]));
        chk({p, "vsp"},  32'(vsp[k]),  32'(m_act[k][7]));
        chk({p, "vch"},  32'(vch[k]),  32'(m_act[k][9]));
        chk({p, "start"}, 32'(sta[k]), 32'(m_act[k][12]) * 256 + 32'(m_act[k][13]));
        chk({p, "cursor"}, 32'(cur[k]), 32'(m_act[k][14]) * 256 + 32'(m_act[k][15]));
        chk({p, "pend"}, 32'(pnd[k]),  32'(m_pend[k]));
        chk({p, "rdata"}, 32'(k == 0 ? bus0.cpu_data_out : bus1.cpu_data_out), 32'(m_rd[k]));
    endtask

    task automatic step(input bit r, input bit en, input bit rw, input bit rs,
                        input logic [7:0] d, input bit f);
        rst_s = r; fs_s = f;
        bus0.cpu_en = en; bus0.cpu_rw = rw; bus0.cpu_rs = rs; bus0.cpu_data_in = d;
        bus1.cpu_en = en; bus1.cpu_rw = rw; bus1.cpu_rs = rs; bus1.cpu_data_in = d;
        @(posedge clk);
        #1;
        model_step(0, 1'b1, r, en, rw, rs, d, f);
        model_step(1, 1'b0, r, en, rw, rs, d, f);
        check_inst(0);
        check_inst(1);
    endtask

    task automatic wr_addr(input logic [7:0] d); step(0, 1, 0, 0, d, 0); endtask
    task automatic wr_data(input logic [7:0] d, input bit f); step(0, 1, 0, 1, d, f); endtask
    task automatic rd(input bit rs); step(0, 1, 1, rs, 8'h00, 0); endtask
    task automatic idle(input bit f); step(0, 0, 0, 0, 8'h00, f); endtask

    initial begin
        bit r, en, rw, rs, f;
        logic [7:0] d;

        rst_s = 1'b1; fs_s = 1'b0;
        bus0.cpu_en = 0; bus0.cpu_rw = 0; bus0.cpu_rs = 0; bus0.cpu_data_in = 0;
        bus1.cpu_en = 0; bus1.cpu_rw = 0; bus1.cpu_rs = 0; bus1.cpu_data_in = 0;
        step(1, 0, 0, 0, 8'h00, 0);
        idle(0);
        chk("rst.r0", 32'(hct[0]), 49);
        chk("rst.r1", 32'(hcd[0]), 40);
        chk("rst.r4", 32'(vct[0]), 32);
        chk("rst.r9", 32'(vch[0]), 7);
        chk("rst.hsw", 32'(hsw[0]), 32'hF);
        chk("rst.vsw", 32'(vsw[0]), 32'h1);
        rd(0);
        chk("rst.status", 32'(bus0.cpu_data_out), 0);

        wr_addr(8'd0);
        wr_data(8'd63, 0);
        chk("r0.held", 32'(hct[0]), 49);
        chk("r0.pend", 32'(pnd[0]), 1);
        idle(1);
        chk("r0.xfer", 32'(hct[0]), 63);
        chk("r0.pend_clr", 32'(pnd[0]), 0);

        wr_addr(8'd14); wr_data(8'hFF, 0);
        wr_addr(8'd15); wr_data(8'h34, 0);
        chk("cursor", 32'(cur[0]), 32'h3F34);
        wr_addr(8'd14); rd(1);
        chk("rd.r14", 32'(bus0.cpu_data_out), 32'h3F);
        wr_addr(8'd15); rd(1);
        chk("rd.r15", 32'(bus0.cpu_data_out), 32'h34);
        chk("cursor.pend", 32'(pnd[0]), 0);

        wr_addr(8'd1); wr_data(8'd80, 0);
        wr_addr(8'd6); wr_data(8'hFF, 1);
        chk("coll.r1", 32'(hcd[0]), 80);
        chk("coll.r6", 32'(vcd[0]), 25);
        chk("coll.pend", 32'(pnd[0]), 1);
        idle(1);
        chk("coll.r6_next", 32'(vcd[0]), 32'h7F);

        wr_addr(8'd8);  wr_data(8'hAA, 0);
        wr_addr(8'd20); wr_data(8'h55, 0);
        chk("ign.pend", 32'(pnd[0]), 0);
        chk("ign.r0", 32'(hct[0]), 63);
        wr_addr(8'd3); rd(1);
        chk("rd.r3", 32'(bus0.cpu_data_out), 0);
        wr_addr(8'hE5); rd(0);
        chk("addr.mask", 32'(bus0.cpu_data_out), 32'h05);

        wr_addr(8'd2); wr_data(8'd45, 0);
        idle(0);
        chk("fs0.r2", 32'(hsp[1]), 45);
        chk("fs0.pend", 32'(pnd[1]), 0);
        chk("fs1.r2_held", 32'(hsp[0]), 41);
        step(1, 1, 0, 1, 8'd99, 1);
        chk("rst.mid.r2", 32'(hsp[1]), 41);
        chk("rst.mid.r0", 32'(hct[0]), 49);
        chk("rst.mid.cur", 32'(cur[0]), 0);
        chk("rst.mid.pend", 32'(pnd[0]), 0);

        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 79) == 0);
            en = ($urandom_range(0, 3) != 0);
            rw = ($urandom_range(0, 2) == 0);
            rs = $urandom_range(0, 1) == 1;
            d  = 8'($urandom);
            if (!rw && !rs && $urandom_range(0, 3) != 0)
                d = {d[7:5], 5'($urandom_range(0, 15))};
            f  = ($urandom_range(0, 5) == 0);
            step(r, en, rw, rs, d, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
